// File: rtl/slice_reg_cfg_pkg.sv
// Shared definitions for the SLICE register configuration consumer:
// word layout, field enums, the unpacked word struct and the loader FSM states.
package slice_reg_cfg_pkg;

    localparam int CFG_W = 8;
    localparam int CNT_W = 4;

    localparam int SRMODE_BIT   = 7;
    localparam int GSR_BIT      = 6;
    localparam int LSRMODE1_BIT = 5;
    localparam int SEL1_BIT     = 4;
    localparam int REGSET1_BIT  = 3;
    localparam int LSRMODE0_BIT = 2;
    localparam int SEL0_BIT     = 1;
    localparam int REGSET0_BIT  = 0;

    typedef enum logic {SRMODE_LSR_OVER_CE = 1'b0, SRMODE_ASYNC = 1'b1} srmode_e;
    typedef enum logic {LSRMODE_LSR = 1'b0, LSRMODE_PRLD = 1'b1} lsrmode_e;
    typedef enum logic {SEL_DF = 1'b0, SEL_DL = 1'b1} sel_e;
    typedef enum logic {REGSET_RESET = 1'b0, REGSET_SET = 1'b1} regset_e;

    typedef struct packed {
        srmode_e  srmode;
        logic     gsr;
        lsrmode_e lsrmode1;
        sel_e     sel1;
        regset_e  regset1;
        lsrmode_e lsrmode0;
        sel_e     sel0;
        regset_e  regset0;
    } cfg_word_t;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

    // Field-by-field unpack keeps the bit positions in one place.
    function automatic cfg_word_t unpack_cfg(input logic [CFG_W-1:0] w);
        cfg_word_t c;
        c.srmode   = srmode_e'(w[SRMODE_BIT]);
        c.gsr      = w[GSR_BIT];
        c.lsrmode1 = lsrmode_e'(w[LSRMODE1_BIT]);
        c.sel1     = sel_e'(w[SEL1_BIT]);
        c.regset1  = regset_e'(w[REGSET1_BIT]);
        c.lsrmode0 = lsrmode_e'(w[LSRMODE0_BIT]);
        c.sel0     = sel_e'(w[SEL0_BIT]);
        c.regset0  = regset_e'(w[REGSET0_BIT]);
        return c;
    endfunction

endpackage

// File: rtl/slice_reg_bit.sv
// One slice register: GSR / LSR / CE priority next-state logic plus the
// combinational async-LSR output override. A commit edge loads the new REGSET.
module slice_reg_bit
    import slice_reg_cfg_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_commit,
    input  regset_e  i_newRegset,
    input  regset_e  i_regset,
    input  sel_e     i_sel,
    input  lsrmode_e i_lsrmode,
    input  logic     i_gsrEn,
    input  srmode_e  i_srmode,
    input  logic     i_f,
    input  logic     i_m,
    input  logic     i_ce,
    input  logic     i_lsr,
    input  logic     i_gsrN,
    output logic     o_q
);

    logic r_q;
    logic w_lsrLoad;
    logic w_d;

    assign w_lsrLoad = (i_lsrmode == LSRMODE_PRLD) ? i_m : (i_regset == REGSET_SET);
    assign w_d       = (i_sel == SEL_DL) ? i_m : i_f;

    // LSR acts regardless of CE in both modes; async mode additionally bypasses the flop below.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= 1'b0;
        end else if (i_commit) begin
            r_q <= (i_newRegset == REGSET_SET);
        end else if (i_gsrEn && !i_gsrN) begin
            r_q <= (i_regset == REGSET_SET);
        end else if (i_lsr) begin
            r_q <= w_lsrLoad;
        end else if (i_ce) begin
            r_q <= w_d;
        end
    end

    assign o_q = ((i_srmode == SRMODE_ASYNC) && i_lsr) ? w_lsrLoad : r_q;

endmodule

// File: rtl/slice_reg_cfg_apply.sv
// Serial loader for the 8-bit SLICE register config word: shifts into a shadow,
// commits atomically on a clean 8-bit burst, and drives the Q0/Q1 register pair.
module slice_reg_cfg_apply
    import slice_reg_cfg_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    input  logic CFG_SEN,
    input  logic CFG_SDI,
    input  logic F0,
    input  logic F1,
    input  logic M0,
    input  logic M1,
    input  logic CE,
    input  logic LSR,
    input  logic GSR_N,
    output logic Q0,
    output logic Q1,
    output logic CFG_VALID,
    output logic CFG_ERR
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_W + 1);

    state_e           r_state;
    state_e           w_nextState;
    logic [CFG_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_count;
    cfg_word_t        r_cfg;
    cfg_word_t        w_newCfg;
    logic             r_valid;
    logic             r_err;
    logic             w_commit;
    logic             w_abort;

    assign w_newCfg = unpack_cfg(r_shadow);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A burst ends when enable drops; only an exact 8-bit count commits.
    always_comb begin
        w_nextState = r_state;
        w_commit    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (CFG_SEN) begin
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (!CFG_SEN) begin
                    w_nextState = IDLE;
                    if (r_count == CNT_FULL) begin
                        w_commit = 1'b1;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_shadow <= '0;
            r_count  <= '0;
            r_cfg    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (CFG_SEN) begin
                r_shadow <= {r_shadow[CFG_W-2:0], CFG_SDI};
                if (r_state == IDLE) begin
                    r_count <= CNT_W'(1);
                end else if (r_count != CNT_SAT) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else begin
                r_count <= '0;
            end
            if (w_commit) begin
                r_cfg   <= w_newCfg;
                r_valid <= 1'b1;
                r_err   <= 1'b0;
            end else if (w_abort) begin
                r_err   <= 1'b1;
            end
        end
    end

    slice_reg_bit u_reg0 (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_commit    (w_commit),
        .i_newRegset (w_newCfg.regset0),
        .i_regset    (r_cfg.regset0),
        .i_sel       (r_cfg.sel0),
        .i_lsrmode   (r_cfg.lsrmode0),
        .i_gsrEn     (r_cfg.gsr),
        .i_srmode    (r_cfg.srmode),
        .i_f         (F0),
        .i_m         (M0),
        .i_ce        (CE),
        .i_lsr       (LSR),
        .i_gsrN      (GSR_N),
        .o_q         (Q0)
    );

    slice_reg_bit u_reg1 (
        .i_clk       (CLK),
        .i_rst_n     (RST_N),
        .i_commit    (w_commit),
        .i_newRegset (w_newCfg.regset1),
        .i_regset    (r_cfg.regset1),
        .i_sel       (r_cfg.sel1),
        .i_lsrmode   (r_cfg.lsrmode1),
        .i_gsrEn     (r_cfg.gsr),
        .i_srmode    (r_cfg.srmode),
        .i_f         (F1),
        .i_m         (M1),
        .i_ce        (CE),
        .i_lsr       (LSR),
        .i_gsrN      (GSR_N),
        .o_q         (Q1)
    );

    assign CFG_VALID = r_valid;
    assign CFG_ERR   = r_err;

endmodule

// File: doc/slice_reg_cfg_apply.md
Name: slice_reg_cfg_apply

Overview:
- Consumer side of the SLICE register configuration that the reg-config fuzzer writes into the bitstream.
- Receives a serial 8-bit register-configuration word: REGSET, SEL, LSRMODE per register, plus shared GSR and SRMODE.
- Holds the word in a shadow register, commits it atomically, and drives the slice register pair Q0/Q1 exactly as the committed configuration dictates.
- Serves as the behavioural check model against which decoded fuzzer bits are validated in simulation.

Parameters:
- CFG_W, 8, configuration word width in bits; fixed layout, not to be changed.
- CNT_W, 4, bit-counter width; counter saturates at CFG_W+1.

Ports:
- CLK  input  1  single clock; all sequential logic on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- CFG_SEN  input  1  serial config enable; one bit shifted per cycle while high.
- CFG_SDI  input  1  serial config data, MSB first.
- F0, F1  input  1 each  LUT outputs (register D when SEL=DF).
- M0, M1  input  1 each  direct inputs (D when SEL=DL; preload value when LSRMODE=PRLD).
- CE  input  1  clock enable, shared by both registers.
- LSR  input  1  local set/reset, shared, active-high.
- GSR_N  input  1  global set/reset, active-low, sampled synchronously.
- Q0, Q1  output  1 each  register outputs.
- CFG_VALID  output  1  at least one good commit since reset.
- CFG_ERR  output  1  sticky: last shift burst was not exactly 8 bits.

Behaviour:
- Word layout:
  - [7] SRMODE (0=LSR_OVER_CE, 1=ASYNC)
  - [6] GSR (1=ENABLED)
  - [5] LSRMODE1 (0=LSR, 1=PRLD), [4] SEL1 (0=DF, 1=DL), [3] REGSET1 (0=RESET, 1=SET)
  - [2:0] same fields for register 0.
- Reset (RST_N low, async): state IDLE, counter 0, shadow 0, active cfg 0, q_reg0/1 = 0, Q0=Q1=0, CFG_VALID=0, CFG_ERR=0. Reset mid-shift discards the partial word.
- FSM IDLE -> SHIFT: on an edge with CFG_SEN=1. The first bit is captured at that same edge and the counter becomes 1.
- In SHIFT with CFG_SEN=1: shadow <= {shadow[6:0], CFG_SDI}; counter increments, saturating at 9.
- In SHIFT with CFG_SEN=0, count==8 (commit, 1-cycle latency):
  - active cfg <= shadow at this edge;
  - q_regk <= new REGSETk;
  - CFG_VALID <= 1, CFG_ERR <= 0;
  - next state IDLE.
- In SHIFT with CFG_SEN=0, count!=8 (abort): active cfg and q_regs unchanged; CFG_ERR <= 1; next state IDLE; counter cleared.
- While shifting, the data path keeps running on the old active cfg.
- Per-register next state on each edge, when not committing. Priority high to low:
  1. GSR enabled and GSR_N=0: q <= REGSET.
  2. LSR=1 and (SRMODE=ASYNC, or LSR_OVER_CE, which ignores CE): q <= (LSRMODE=PRLD ? Mk : REGSETk).
  3. CE=1: q <= (SEL=DL ? Mk : Fk).
  4. Otherwise hold.
- Output: SRMODE=ASYNC and LSR=1 gives Qk = LSR load value combinationally, zero latency. Otherwise Qk = q_regk.
- A commit edge overrides GSR, LSR and CE for that edge.
- No counter wrap: more than 8 bits saturates the counter and aborts.

Decomposition:
- Package slice_reg_cfg_pkg holds:
  - the field bit-index constants;
  - enums for SRMODE, LSRMODE, SEL, REGSET;
  - a packed struct for the 8-bit word;
  - the FSM state enum {IDLE, SHIFT}.
- Sub-module slice_reg_bit: one register's next-state and output logic. It takes its 3 config fields plus shared GSR/SRMODE, is instantiated twice, and receives commit as an input.

Test Plan:
- Reset, then shift 0x09 (REGSET0=1, REGSET1=1), drop CFG_SEN -> one edge later Q0=Q1=1, CFG_VALID=1, CFG_ERR=0.
- Commit 0x12 (SEL0=DL, SEL1=DL); CE=1, M0=1, F0=0, M1=0 -> Q0=1, Q1=0 after one edge; CE=0 with inputs toggled -> Q0/Q1 hold.
- Commit 0x04 (LSRMODE0=PRLD, LSR_OVER_CE); CE=0, LSR=1, M0=1 -> Q0=1 and Q1=0 after one edge.
- Commit 0x80 (ASYNC); Q0=1 via CE=1, F0=1, then LSR=1 mid-cycle -> Q0 drops to 0 before the next edge and stays 0 after it.
- Shift 7 bits, then separately 9 bits -> CFG_ERR=1, active cfg and Q unchanged; a following good 8-bit commit -> CFG_ERR=0.
- Commit 0x41 (GSR on, REGSET0=1); GSR_N=0 with LSR=1, CE=1, F0=0 -> Q0=1 (GSR wins). RST_N low mid-shift -> all outputs 0 immediately, CFG_VALID=0.
